// File: rtl/unidade_es_pkg.sv
// Shared types and constants for the I/O responder.
// State encoding and debounce counter sizing.
package unidade_es_pkg;

  localparam int LARGURA_DADO = 32;

  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,
    ESPERA_BOTAO = 2'd1,
    CAPTURA      = 2'd2,
    PARADO       = 2'd3
  } estado_t;

  function automatic int largura_filtro(input int ciclos);
    return (ciclos < 1) ? 1 : $clog2(ciclos + 1);
  endfunction

endpackage

// File: rtl/filtro_botao.sv
// Button synchronizer, stability filter and press detection.
// Emits the debounced level and a one-cycle rising-edge pulse.
module filtro_botao
  import unidade_es_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 1000
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic botao_i,
  output logic nivel_o,
  output logic pressao_o
);

  localparam int W = largura_filtro(DEBOUNCE_CICLOS);
  localparam logic [W-1:0] LIMITE = W'(DEBOUNCE_CICLOS - 1);

  logic         sinc1_q, sinc2_q;
  logic         nivel_q, nivel_d;
  logic         pressao_q, pressao_d;
  logic [W-1:0] cont_q, cont_d;

  // Level only follows the input after it has disagreed long enough.
  always_comb begin
    nivel_d   = nivel_q;
    pressao_d = 1'b0;
    cont_d    = '0;
    if (sinc2_q != nivel_q) begin
      if (cont_q >= LIMITE) begin
        nivel_d   = sinc2_q;
        pressao_d = sinc2_q;
      end else begin
        cont_d = cont_q + W'(1);
      end
    end
  end

  // Synchronizer and filter state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sinc1_q   <= 1'b0;
      sinc2_q   <= 1'b0;
      nivel_q   <= 1'b0;
      pressao_q <= 1'b0;
      cont_q    <= '0;
    end else begin
      sinc1_q   <= botao_i;
      sinc2_q   <= sinc1_q;
      nivel_q   <= nivel_d;
      pressao_q <= pressao_d;
      cont_q    <= cont_d;
    end
  end

  assign nivel_o   = nivel_q;
  assign pressao_o = pressao_q;

endmodule

// File: rtl/unidade_es.sv
// I/O responder: IN stall/capture, OUT display latch, HLT park.
// Define QUANTUM_EN to build the scheduler quantum counter.
module unidade_es
  import unidade_es_pkg::*;
#(
  parameter int LARGURA_CHAVES  = 16,
  parameter int DEBOUNCE_CICLOS = 1000,
  parameter int LARGURA_QUANTUM = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      escreverIn,
  input  logic                      escreverOut,
  input  logic                      escreverQuantum,
  input  logic                      halt,
  input  logic [31:0]               dadoOut,
  input  logic [LARGURA_CHAVES-1:0] chaves,
  input  logic                      botao,
  output logic [31:0]               dadoIn,
  output logic                      pausa,
  output logic [31:0]               display,
  output logic                      esperandoEntrada,
  output logic                      parado,
  output logic                      trocaContexto
);

  estado_t                 estado_q, estado_d;
  logic [LARGURA_DADO-1:0] dadoIn_q, dadoIn_d;
  logic [LARGURA_DADO-1:0] display_q, display_d;
  logic                    pressao;
  logic                    nivel_unused;

  filtro_botao #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_filtro (
    .clock_i  (clock),
    .reset_i  (reset),
    .botao_i  (botao),
    .nivel_o  (nivel_unused),
    .pressao_o(pressao)
  );

  // Stall is combinational so IN/HLT hold the core in their first cycle.
  assign pausa = ((estado_q == OCIOSO) & (escreverIn | halt))
               | (estado_q == ESPERA_BOTAO)
               | (estado_q == PARADO);

  // Next state, capture and display update.
  always_comb begin
    estado_d  = estado_q;
    dadoIn_d  = dadoIn_q;
    display_d = display_q;
    unique case (estado_q)
      OCIOSO: begin
        if (halt) begin
          estado_d = PARADO;
        end else if (escreverIn) begin
          estado_d = ESPERA_BOTAO;
        end else if (escreverOut) begin
          display_d = dadoOut;
        end
      end
      ESPERA_BOTAO: begin
        if (pressao) begin
          dadoIn_d = LARGURA_DADO'(chaves);
          estado_d = CAPTURA;
        end
      end
      CAPTURA: estado_d = OCIOSO;
      PARADO:  estado_d = PARADO;
    endcase
  end

  // Architectural state of the responder.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      dadoIn_q  <= '0;
      display_q <= '0;
    end else begin
      estado_q  <= estado_d;
      dadoIn_q  <= dadoIn_d;
      display_q <= display_d;
    end
  end

  assign dadoIn           = dadoIn_q;
  assign display          = display_q;
  assign esperandoEntrada = (estado_q == ESPERA_BOTAO);
  assign parado           = (estado_q == PARADO);

`ifdef QUANTUM_EN
  logic [LARGURA_QUANTUM-1:0] quantum_q, quantum_d;
  logic [LARGURA_QUANTUM-1:0] contq_q, contq_d;
  logic                       troca_q, troca_d;
  logic                       carga;

  assign carga = (estado_q == OCIOSO) & escreverQuantum;

  // Load wins over countdown; expiry reloads and pulses once.
  always_comb begin
    quantum_d = quantum_q;
    contq_d   = contq_q;
    troca_d   = 1'b0;
    if (carga) begin
      quantum_d = dadoOut[LARGURA_QUANTUM-1:0];
      contq_d   = dadoOut[LARGURA_QUANTUM-1:0];
    end else if (!pausa && contq_q != '0) begin
      if (contq_q == LARGURA_QUANTUM'(1)) begin
        contq_d = quantum_q;
        troca_d = 1'b1;
      end else begin
        contq_d = contq_q - LARGURA_QUANTUM'(1);
      end
    end
  end

  // Quantum register, countdown and expiry pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      quantum_q <= '0;
      contq_q   <= '0;
      troca_q   <= 1'b0;
    end else begin
      quantum_q <= quantum_d;
      contq_q   <= contq_d;
      troca_q   <= troca_d;
    end
  end

  assign trocaContexto = troca_q;
`else
  logic qtm_unused;
  assign qtm_unused    = escreverQuantum;
  assign trocaContexto = 1'b0;
`endif

endmodule

// File: tb/tb_unidade_es.sv
// Self-checking bench for unidade_es with a short debounce.
// Directed table plus hand sequences for IN, reset, HLT and quantum.
module tb_unidade_es;

  logic        clock = 1'b0;
  logic        reset;
  logic        escreverIn, escreverOut, escreverQuantum, halt;
  logic [31:0] dadoOut;
  logic [15:0] chaves;
  logic        botao;
  logic [31:0] dadoIn, display;
  logic        pausa, esperandoEntrada, parado, trocaContexto;

  int total = 0;
  int bad   = 0;

  unidade_es #(
    .LARGURA_CHAVES (16),
    .DEBOUNCE_CICLOS(4),
    .LARGURA_QUANTUM(32)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .escreverIn      (escreverIn),
    .escreverOut     (escreverOut),
    .escreverQuantum (escreverQuantum),
    .halt            (halt),
    .dadoOut         (dadoOut),
    .chaves          (chaves),
    .botao           (botao),
    .dadoIn          (dadoIn),
    .pausa           (pausa),
    .display         (display),
    .esperandoEntrada(esperandoEntrada),
    .parado          (parado),
    .trocaContexto   (trocaContexto)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        esc_out;
    logic [31:0] d_out;
    logic        exp_pausa;
    logic [31:0] exp_display;
  } vetor_t;

  vetor_t tab[6];

  task automatic chk(input string nome, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nome, got, exp, $time);
    end
  endtask

  task automatic passo();
    @(posedge clock);
    #1;
  endtask

  task automatic ocioso();
    escreverIn      = 1'b0;
    escreverOut     = 1'b0;
    escreverQuantum = 1'b0;
    halt            = 1'b0;
    dadoOut         = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ocioso();
    botao = 1'b0;
    passo();
    passo();
    reset = 1'b0;
  endtask

  initial begin
    chaves = '0;
    do_reset();

    @(negedge clock);
    chk("rst_pausa", 32'(pausa), 0);
    chk("rst_display", display, 0);
    chk("rst_dadoIn", dadoIn, 0);
    chk("rst_parado", 32'(parado), 0);
    chk("rst_troca", 32'(trocaContexto), 0);
    chk("rst_espera", 32'(esperandoEntrada), 0);
    passo();

    tab[0] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
    tab[1] = '{1'b1, 32'h0000_00A5, 1'b0, 32'h0000_00A5};
    tab[2] = '{1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0000_00A5};
    tab[3] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
    tab[4] = '{1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
    tab[5] = '{1'b1, 32'h1234_5678, 1'b0, 32'h1234_5678};

    for (int i = 0; i < 6; i++) begin
      escreverOut = tab[i].esc_out;
      dadoOut     = tab[i].d_out;
      @(negedge clock);
      chk($sformatf("tab%0d_pausa", i), 32'(pausa), 32'(tab[i].exp_pausa));
      passo();
      chk($sformatf("tab%0d_display", i), display, tab[i].exp_display);
      chk($sformatf("tab%0d_parado", i), 32'(parado), 0);
    end
    ocioso();

    // IN with switches and a clean press
    do_reset();
    escreverIn = 1'b1;
    chaves     = 16'h1234;
    @(negedge clock);
    chk("in_pausa_first", 32'(pausa), 1);
    passo();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("in_pausa_wait", 32'(pausa), 1);
      chk("in_espera", 32'(esperandoEntrada), 1);
      passo();
    end
    botao = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      chk($sformatf("in_pausa_deb%0d", i), 32'(pausa), 1);
      passo();
    end
    @(negedge clock);
    chk("captura_pausa", 32'(pausa), 0);
    chk("captura_dadoIn", dadoIn, 32'h0000_1234);
    chk("captura_espera", 32'(esperandoEntrada), 0);
    passo();
    escreverIn = 1'b0;
    botao      = 1'b0;
    chaves     = 16'hBEEF;
    @(negedge clock);
    chk("pos_in_pausa", 32'(pausa), 0);
    chk("pos_in_dadoIn", dadoIn, 32'h0000_1234);
    repeat (8) passo();

    // glitch during wait, then reset mid-wait
    escreverIn = 1'b1;
    passo();
    botao = 1'b1;
    passo();
    passo();
    botao = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("glitch_pausa", 32'(pausa), 1);
      passo();
    end
    chk("glitch_dadoIn", dadoIn, 32'h0000_1234);
    reset = 1'b1;
    passo();
    reset      = 1'b0;
    escreverIn = 1'b0;
    @(negedge clock);
    chk("rst_wait_pausa", 32'(pausa), 0);
    chk("rst_wait_espera", 32'(esperandoEntrada), 0);
    chk("rst_wait_dadoIn", dadoIn, 0);
    passo();

    // button already debounced high before IN: no capture
    botao = 1'b1;
    repeat (8) passo();
    escreverIn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("held_pausa", 32'(pausa), 1);
      passo();
    end
    chk("held_dadoIn", dadoIn, 0);

    // priority IN over OUT
    do_reset();
    escreverIn  = 1'b1;
    escreverOut = 1'b1;
    dadoOut     = 32'h0000_0055;
    passo();
    chk("prio_espera", 32'(esperandoEntrada), 1);
    chk("prio_display", display, 0);

    // HLT
    do_reset();
    escreverOut = 1'b1;
    dadoOut     = 32'h0000_0033;
    passo();
    halt    = 1'b1;
    dadoOut = 32'h0000_0007;
    @(negedge clock);
    chk("hlt_pausa", 32'(pausa), 1);
    chk("hlt_parado_pre", 32'(parado), 0);
    passo();
    halt = 1'b0;
    @(negedge clock);
    chk("hlt_parado", 32'(parado), 1);
    chk("hlt_pausa_hold", 32'(pausa), 1);
    chk("hlt_display", display, 32'h0000_0033);
    passo();
    chk("hlt_display_out", display, 32'h0000_0033);
    chk("hlt_parado_stay", 32'(parado), 1);

    // quantum: QTM with 3, pulse after 3 and 6 unstalled cycles
    do_reset();
    escreverQuantum = 1'b1;
    dadoOut         = 32'd3;
    passo();
    ocioso();
    for (int c = 1; c <= 7; c++) begin
      logic e;
`ifdef QUANTUM_EN
      e = (c == 4) || (c == 7);
`else
      e = 1'b0;
`endif
      @(negedge clock);
      chk($sformatf("qtm_c%0d", c), 32'(trocaContexto), 32'(e));
      passo();
    end
    escreverIn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      chk($sformatf("qtm_stall%0d", c), 32'(trocaContexto), 0);
      passo();
    end
    ocioso();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
